// File: rtl/pipelined_alu.sv
// pipelined_alu: two-stage ALU (add/sub/logic/compare) followed by a logical barrel shifter with carry/zero flags.
// Latency: 2 cycles from input acceptance to Out_valid; sustains one operation per cycle while Out_ready=1.
// Backpressure: Out_ready=0 holds stage 2 stable, then stage 1 fills and In_ready drops; at most 2 ops held.
// Option: define PIPELINED_ALU_SATURATE_EN to clamp add overflow to all-ones and sub underflow to zero.
module pipelined_alu #(
  parameter  int WIDTH   = 16,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               In_valid,
  output logic               In_ready,
  input  logic [2:0]         ALU_control,
  input  logic               Shift_right,
  input  logic [SHAMT_W-1:0] Shift_amount,
  input  logic [WIDTH-1:0]   Ainput,
  input  logic [WIDTH-1:0]   Binput,
  output logic               Out_valid,
  input  logic               Out_ready,
  output logic [WIDTH-1:0]   Shift_output,
  output logic               Carry_flag,
  output logic               Zero_flag
);

  // Stage 1 state: ALU result plus the shift controls that travel with it
  logic               s1_valid;
  logic [WIDTH-1:0]   s1_res;
  logic               s1_carry;
  logic               s1_shr;
  logic [SHAMT_W-1:0] s1_shamt;

  // Stage 2 state is the output register itself
  logic               s2_valid;
  logic               s2_ready;

  logic [WIDTH:0]     add_full;
  logic [WIDTH:0]     sub_full;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic [WIDTH-1:0]   shifted;

  // Stage 2 can take new data when empty or when its content leaves this cycle;
  // stage 1 can then accept whenever it is empty or moves into stage 2.
  assign s2_ready  = !s2_valid || Out_ready;
  assign In_ready  = !s1_valid || s2_ready;
  assign Out_valid = s2_valid;

  // One extra bit captures carry-out for add and borrow for sub
  assign add_full = {1'b0, Ainput} + {1'b0, Binput};
  assign sub_full = {1'b0, Ainput} - {1'b0, Binput};

  // Operation decode; carry is only meaningful for add/sub
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (ALU_control)
      3'b000: begin
        alu_carry = add_full[WIDTH];
`ifdef PIPELINED_ALU_SATURATE_EN
        alu_res   = add_full[WIDTH] ? {WIDTH{1'b1}} : add_full[WIDTH-1:0];
`else
        alu_res   = add_full[WIDTH-1:0];
`endif
      end
      3'b001: begin
        alu_carry = sub_full[WIDTH];
`ifdef PIPELINED_ALU_SATURATE_EN
        alu_res   = sub_full[WIDTH] ? {WIDTH{1'b0}} : sub_full[WIDTH-1:0];
`else
        alu_res   = sub_full[WIDTH-1:0];
`endif
      end
      3'b010:  alu_res = Ainput & Binput;
      3'b011:  alu_res = Ainput | Binput;
      3'b100:  alu_res = Ainput ^ Binput;
      3'b101:  alu_res = Ainput;
      3'b110:  alu_res = {{(WIDTH-1){1'b0}}, (Ainput < Binput)};
      default: alu_res = '0;
    endcase
  end

  // Logical shift of the stage 1 result; vacated bits fill with zero either way
  always_comb begin
    shifted = s1_shr ? (s1_res >> s1_shamt) : (s1_res << s1_shamt);
  end

  // Stage 1 register: load on input transfer, drain when moving into stage 2
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid <= 1'b0;
      s1_res   <= '0;
      s1_carry <= 1'b0;
      s1_shr   <= 1'b0;
      s1_shamt <= '0;
    end else if (In_ready) begin
      s1_valid <= In_valid;
      if (In_valid) begin
        s1_res   <= alu_res;
        s1_carry <= alu_carry;
        s1_shr   <= Shift_right;
        s1_shamt <= Shift_amount;
      end
    end
  end

  // Stage 2 register: outputs only change when the held result is consumed or absent
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      s2_valid     <= 1'b0;
      Shift_output <= '0;
      Carry_flag   <= 1'b0;
      Zero_flag    <= 1'b0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        Shift_output <= shifted;
        Carry_flag   <= s1_carry;
        Zero_flag    <= (shifted == '0);
      end
    end
  end

endmodule

// File: tb/tb_pipelined_alu.sv
// tb_pipelined_alu: directed and randomized checks of pipelined_alu against a queue-based reference model.
// Latency: each step is one Clock cycle; outputs are sampled 1ns after the falling edge.
// Backpressure: Out_ready is driven by the bench to exercise stalls and full-pipeline hold.
module tb_pipelined_alu;
  localparam int     W    = 16;
  localparam int     SW   = 4;
  localparam longint MASK = (64'd1 << W) - 1;

  logic          Clock = 1'b0;
  logic          Reset_n = 1'b1;
  logic          In_valid = 1'b0;
  logic          In_ready;
  logic [2:0]    ALU_control = '0;
  logic          Shift_right = 1'b0;
  logic [SW-1:0] Shift_amount = '0;
  logic [W-1:0]  Ainput = '0;
  logic [W-1:0]  Binput = '0;
  logic          Out_valid;
  logic          Out_ready = 1'b0;
  logic [W-1:0]  Shift_output;
  logic          Carry_flag;
  logic          Zero_flag;

  pipelined_alu #(.WIDTH(W)) dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .In_valid     (In_valid),
    .In_ready     (In_ready),
    .ALU_control  (ALU_control),
    .Shift_right  (Shift_right),
    .Shift_amount (Shift_amount),
    .Ainput       (Ainput),
    .Binput       (Binput),
    .Out_valid    (Out_valid),
    .Out_ready    (Out_ready),
    .Shift_output (Shift_output),
    .Carry_flag   (Carry_flag),
    .Zero_flag    (Zero_flag)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         z;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           failures = 0;
  int           delivered = 0;
  logic         held_vld = 1'b0;
  logic [W-1:0] held_res = '0;
  logic         held_c = 1'b0;
  logic         held_z = 1'b0;
  logic         last_in_ready = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation table, then the shift
  function automatic exp_t model(input logic [2:0] op, input logic shr, input int sh,
                                 input longint a, input longint b);
    exp_t   m;
    longint r;
    logic   c;
    c = 1'b0;
    case (op)
      3'd0: begin
        r = a + b;
        c = (r > MASK);
        r = r & MASK;
`ifdef PIPELINED_ALU_SATURATE_EN
        if (c) r = MASK;
`endif
      end
      3'd1: begin
        c = (a < b);
        r = (a - b) & MASK;
`ifdef PIPELINED_ALU_SATURATE_EN
        if (c) r = 0;
`endif
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a;
      3'd6: r = (a < b) ? 64'd1 : 64'd0;
      default: r = 0;
    endcase
    r = shr ? (r >> sh) : ((r << sh) & MASK);
    m.res = r[W-1:0];
    m.c   = c;
    m.z   = (r == 0);
    return m;
  endfunction

  // One clock cycle: drive, check the scoreboard and hold rules, record transfers
  task automatic step(input logic iv, input logic [2:0] op, input logic shr, input logic [SW-1:0] sh,
                      input logic [W-1:0] a, input logic [W-1:0] b, input logic ordy, output logic acc);
    exp_t e;
    In_valid     = iv;
    ALU_control  = op;
    Shift_right  = shr;
    Shift_amount = sh;
    Ainput       = a;
    Binput       = b;
    Out_ready    = ordy;
    #1;
    if (held_vld) begin
      chk("hold_vld", 32'(Out_valid), 32'd1);
      chk("hold_res", 32'(Shift_output), 32'(held_res));
      chk("hold_c", 32'(Carry_flag), 32'(held_c));
      chk("hold_z", 32'(Zero_flag), 32'(held_z));
    end
    chk("in_ready", 32'(In_ready), 32'((exp_q.size() < 2) || ordy));
    if (exp_q.size() == 0) chk("no_spurious_out", 32'(Out_valid), 32'd0);
    if (exp_q.size() == 2) chk("full_out_vld", 32'(Out_valid), 32'd1);
    if (Out_valid && Out_ready && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("res", 32'(Shift_output), 32'(e.res));
      chk("carry", 32'(Carry_flag), 32'(e.c));
      chk("zero", 32'(Zero_flag), 32'(e.z));
      delivered++;
    end
    held_vld      = Out_valid && !Out_ready;
    held_res      = Shift_output;
    held_c        = Carry_flag;
    held_z        = Zero_flag;
    last_in_ready = In_ready;
    acc = In_valid && In_ready;
    if (acc) exp_q.push_back(model(op, shr, int'(sh), longint'(a), longint'(b)));
    @(negedge Clock);
  endtask

  // Single op into an empty pipeline: exact 2-cycle latency and known result
  task automatic directed(input string tag, input logic [2:0] op, input logic shr, input logic [SW-1:0] sh,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic ec, input logic ez);
    logic acc;
    step(1'b1, op, shr, sh, a, b, 1'b1, acc);
    chk({tag, "_acc"}, 32'(acc), 32'd1);
    chk({tag, "_lat1"}, 32'(Out_valid), 32'd0);
    step(1'b0, 3'd0, 1'b0, '0, '0, '0, 1'b1, acc);
    chk({tag, "_lat2"}, 32'(Out_valid), 32'd1);
    chk({tag, "_res"}, 32'(Shift_output), 32'(er));
    chk({tag, "_carry"}, 32'(Carry_flag), 32'(ec));
    chk({tag, "_zero"}, 32'(Zero_flag), 32'(ez));
    step(1'b0, 3'd0, 1'b0, '0, '0, '0, 1'b1, acc);
  endtask

  initial begin
    logic          acc;
    logic [2:0]    rop;
    logic          rshr;
    logic [SW-1:0] rsh;
    logic [W-1:0]  ra;
    logic [W-1:0]  rb;
    int            sent;
    int            cyc;
    int            d0;
    logic          saw_block;

    // Reset state
    #2 Reset_n = 1'b0;
    repeat (2) @(negedge Clock);
    #1;
    chk("rst_out_vld", 32'(Out_valid), 32'd0);
    chk("rst_res", 32'(Shift_output), 32'd0);
    chk("rst_carry", 32'(Carry_flag), 32'd0);
    chk("rst_zero", 32'(Zero_flag), 32'd0);
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
    #1;
    chk("rst_in_ready", 32'(In_ready), 32'd1);
    @(negedge Clock);

    // Directed vectors with known results
`ifdef PIPELINED_ALU_SATURATE_EN
    directed("add_ovf", 3'd0, 1'b0, 4'd0, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
    directed("sub_unf", 3'd1, 1'b0, 4'd1, 16'h0003, 16'h0005, 16'h0000, 1'b1, 1'b1);
`else
    directed("add_ovf", 3'd0, 1'b0, 4'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1);
    directed("sub_unf", 3'd1, 1'b0, 4'd1, 16'h0003, 16'h0005, 16'hFFFC, 1'b1, 1'b0);
`endif
    directed("xor_shr", 3'd4, 1'b1, 4'd4, 16'hF0F0, 16'h0FF0, 16'h0FF0, 1'b0, 1'b0);
    directed("slt_shl", 3'd6, 1'b0, 4'd15, 16'h0001, 16'h8000, 16'h8000, 1'b0, 1'b0);
    directed("zero_op", 3'd7, 1'b0, 4'd3, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1);
    directed("pass_a", 3'd5, 1'b1, 4'd0, 16'hA5C3, 16'h0000, 16'hA5C3, 1'b0, 1'b0);

    // Back-to-back stream of 8 ops with Out_ready low on cycles 3..6
    sent = 0;
    cyc = 0;
    d0 = delivered;
    saw_block = 1'b0;
    while (sent < 8 && cyc < 40) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 16'($urandom_range(0, 65535));
      rb  = 16'($urandom_range(0, 65535));
      rsh = 4'($urandom_range(0, 15));
      step(1'b1, rop, 1'($urandom_range(0, 1)), rsh, ra, rb, (cyc >= 3 && cyc <= 6) ? 1'b0 : 1'b1, acc);
      if (!last_in_ready) saw_block = 1'b1;
      if (acc) sent++;
      cyc++;
    end
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      step(1'b0, 3'd0, 1'b0, '0, '0, '0, 1'b1, acc);
      cyc++;
    end
    chk("stream_sent", 32'(sent), 32'd8);
    chk("stream_delivered", 32'(delivered - d0), 32'd8);
    chk("stream_in_ready_low", 32'(saw_block), 32'd1);

    // Reset with two ops in flight
    step(1'b1, 3'd3, 1'b0, 4'd2, 16'h00F0, 16'h0F00, 1'b0, acc);
    step(1'b1, 3'd0, 1'b1, 4'd1, 16'h0102, 16'h0304, 1'b0, acc);
    #1;
    chk("pre_rst_out_vld", 32'(Out_valid), 32'd1);
    chk("pre_rst_in_ready", 32'(In_ready), 32'd0);
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_out_vld", 32'(Out_valid), 32'd0);
    chk("mid_rst_res", 32'(Shift_output), 32'd0);
    chk("mid_rst_carry", 32'(Carry_flag), 32'd0);
    chk("mid_rst_zero", 32'(Zero_flag), 32'd0);
    exp_q.delete();
    held_vld = 1'b0;
    In_valid = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b1;
    repeat (4) step(1'b0, 3'd0, 1'b0, '0, '0, '0, 1'b1, acc);
    chk("post_rst_out_vld", 32'(Out_valid), 32'd0);

    // Randomized traffic with random backpressure, biased towards carry corners
    repeat (400) begin
      rop  = 3'($urandom_range(0, 7));
      rshr = 1'($urandom_range(0, 1));
      rsh  = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       ra = 16'hFFFF;
        1:       ra = 16'h0000;
        default: ra = 16'($urandom_range(0, 65535));
      endcase
      case ($urandom_range(0, 3))
        0:       rb = 16'h0001;
        1:       rb = 16'hFFFF;
        default: rb = 16'($urandom_range(0, 65535));
      endcase
      step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, rop, rshr, rsh, ra, rb,
           ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, acc);
    end
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      step(1'b0, 3'd0, 1'b0, '0, '0, '0, 1'b1, acc);
      cyc++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_alu.md
PIPELINED_ALU -- requirements
Module: pipelined_alu

Interface
REQ-001 Parameter: WIDTH, 16, datapath width in bits; SHALL be a power of two, 4 to 64.
REQ-002 Parameter: SHAMT_W, $clog2(WIDTH), shift-amount width; SHALL be derived and never overridden.
REQ-003 Port: Clock  in  1  rising-edge clock for all state.
REQ-004 Port: Reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port: In_valid  in  1  input operand set is valid.
REQ-006 Port: In_ready  out  1  block accepts input this cycle.
REQ-007 Port: ALU_control  in  3  operation select (see REQ-013).
REQ-008 Port: Shift_right  in  1  1 = logical right shift, 0 = left shift.
REQ-009 Port: Shift_amount  in  SHAMT_W  shift distance, 0 to WIDTH-1.
REQ-010 Port: Ainput, Binput  in  WIDTH  operands.
REQ-011 Port: Out_valid  out  1 / Out_ready  in  1  output handshake.
REQ-012 Port: Shift_output  out  WIDTH  result / Carry_flag  out  1 / Zero_flag  out  1.

Function
REQ-013 Op codes SHALL be: 000 A+B; 001 A-B; 010 A&B; 011 A|B; 100 A^B; 101 pass A; 110 unsigned A<B (result 1 or 0, zero-extended); 111 result 0.
REQ-014 Add/sub SHALL be modulo 2^WIDTH; Carry is the carry-out for add, borrow (A<B unsigned) for sub, and 0 for all other ops.
REQ-015 Transfer in SHALL occur when In_valid and In_ready are both 1 on a rising edge; transfer out when Out_valid and Out_ready are both 1.
REQ-016 Stage 1 SHALL register the ALU result, Carry, Shift_right and Shift_amount; stage 2 SHALL register the shifted result and flags.
REQ-017 Latency SHALL be exactly 2 cycles: Out_valid rises on the second edge after acceptance when no stall occurs.
REQ-018 Throughput SHALL be one operation per cycle while Out_ready=1.
REQ-019 Each stage SHALL advance when it is empty or the downstream stage advances; In_ready = !s1_valid | s1_advance (combinational).
REQ-020 While Out_valid=1 and Out_ready=0, Shift_output and the flags SHALL hold stable; the pipeline SHALL hold at most 2 operations, with no loss or duplication.
REQ-021 Shift_amount 0 SHALL pass the value unshifted; vacated bits SHALL be 0 in both directions.
REQ-022 Zero_flag SHALL be 1 if and only if the registered Shift_output is all zeros.

Reset
REQ-023 Reset_n=0 SHALL asynchronously clear both stage valid bits, Out_valid, Shift_output, Carry_flag and Zero_flag to 0; In_ready SHALL read 1 one cycle after deassertion.
REQ-024 Reset mid-operation SHALL discard all in-flight operations; no output transfer SHALL follow without a new input transfer.
REQ-025 Reset deassertion is synchronised externally; the block SHALL NOT resynchronise it.

Configuration
REQ-026 Macro PIPELINED_ALU_SATURATE_EN SHALL be the only compile option.
REQ-027 With the macro defined: add overflow SHALL clamp to all-ones, sub underflow SHALL clamp to 0, Carry SHALL still report the raw carry or borrow, and clamping SHALL be applied before the shift.
REQ-028 Without the macro: add/sub SHALL wrap modulo 2^WIDTH with identical timing and ports.

Verification (WIDTH=16)
REQ-029 Op add, A=0xFFFF, B=0x0001, shift 0, Out_ready=1 -> 2 cycles later Shift_output=0x0000, Carry=1, Zero=1; with SATURATE_EN defined, Shift_output=0xFFFF, Zero=0.
REQ-030 Op sub, A=0x0003, B=0x0005, left shift by 1 -> Shift_output=0xFFFC, Carry=1; with SATURATE_EN defined, 0x0000, Zero=1.
REQ-031 Op xor, A=0xF0F0, B=0x0FF0, right shift by 4 -> Shift_output=0x0FF0, Carry=0, Zero=0.
REQ-032 Back-to-back stream of 8 ops with Out_ready=0 from cycles 3 to 6 -> In_ready=0 once 2 ops are held, output held stable, all 8 results delivered in order.
REQ-033 Reset_n pulsed low with 2 ops in flight -> Out_valid=0 immediately, outputs 0, no stale result after release.
REQ-034 Op 110, A=0x0001, B=0x8000, left shift by 15 -> Shift_output=0x8000; op 111 -> 0x0000, Zero=1.
